// File: rtl/led_bank_arbiter_pkg.sv
// Shared types and helpers for the LED bank arbiter: FSM encoding, hold-counter
// width, slice length and pin polarity.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } led_state_e;

  localparam int HOLD_CW = 32;

  function automatic logic [HOLD_CW-1:0] hold_cycles(input int unsigned clk_freq,
                                                     input int unsigned ms);
    return HOLD_CW'(clk_freq / 1000 * ms);
  endfunction

  // lit = 1 means the LED should glow; on_mode is the pin level that lights it
  function automatic logic led_pin(input logic lit, input logic on_mode);
    return on_mode ? lit : ~lit;
  endfunction

endpackage

// File: rtl/led_bank_arbiter_if.sv
// Request/pattern/grant/pin bundle between the pattern generators and the
// LED bank arbiter.
interface led_bank_arbiter_if #(
  parameter int REQ_NUM = 4,
  parameter int LED_NUM = 8
);
  logic [REQ_NUM-1:0]         req_i;
  logic [REQ_NUM*LED_NUM-1:0] pat_i;
  logic [REQ_NUM-1:0]         gnt_o;
  logic                       busy_o;
  logic                       done_o;
  logic [LED_NUM-1:0]         led_o;

  modport master (
    output req_i, pat_i,
    input  gnt_o, busy_o, done_o, led_o
  );

  modport slave (
    input  req_i, pat_i,
    output gnt_o, busy_o, done_o, led_o
  );
endinterface

// File: rtl/led_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo REQ_NUM.
module led_rr_pick #(
  parameter int REQ_NUM = 4
) (
  input  logic [REQ_NUM-1:0]         req,
  input  logic [$clog2(REQ_NUM)-1:0] ptr,
  output logic [REQ_NUM-1:0]         gnt,
  output logic                       valid
);

  always_comb begin
    int unsigned idx;
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      idx = (int'(ptr) + i) % REQ_NUM;
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of a shared LED bank with a minimum hold slice and a dark
// gap between owners. Optional LED_ARB_PREEMPT_EN makes requester 0 preemptive.
module led_bank_arbiter
  import led_pkg::*;
#(
  parameter int   REQ_NUM     = 4,
  parameter int   LED_NUM     = 8,
  parameter logic LED_ON_MODE = 1'b0,
  parameter int   CLK_FREQ    = 50_000_000,
  parameter int   HOLD_MS     = 500
) (
  input logic               clk,
  input logic               rst,
  led_bank_arbiter_if.slave bus
);

  localparam int PW = $clog2(REQ_NUM);
  localparam logic [HOLD_CW-1:0] HOLD_CNT_MAX = hold_cycles(CLK_FREQ, HOLD_MS);
  localparam logic [HOLD_CW-1:0] HOLD_LAST    = HOLD_CNT_MAX - HOLD_CW'(1);

  led_state_e           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [REQ_NUM-1:0]   gnt_q, gnt_d;
  logic [HOLD_CW-1:0]   hold_q, hold_d;
  logic [LED_NUM-1:0]   led_q, led_d;

  logic [REQ_NUM-1:0]   pick_gnt;
  logic                 pick_valid;
  logic [PW-1:0]        pick_idx;
  logic [REQ_NUM-1:0]   win_gnt;
  logic [PW-1:0]        win_idx;
  logic                 preempt;
  logic                 slice_end;
  logic                 release_now;

  led_rr_pick #(.REQ_NUM(REQ_NUM)) u_pick (
    .req   (bus.req_i),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int unsigned i = 0; i < REQ_NUM; i++) begin
      if (pick_gnt[i]) pick_idx = PW'(i);
    end
  end

`ifdef LED_ARB_PREEMPT_EN
  // requester 0 overrides the rotation both at arbitration and mid-slice
  always_comb begin
    win_gnt = pick_gnt;
    win_idx = pick_idx;
    if (bus.req_i[0]) begin
      win_gnt = REQ_NUM'(1);
      win_idx = '0;
    end
  end
  assign preempt = bus.req_i[0] && (owner_q != '0);
`else
  assign win_gnt = pick_gnt;
  assign win_idx = pick_idx;
  assign preempt = 1'b0;
`endif

  assign slice_end   = (hold_q == HOLD_LAST);
  assign release_now = !bus.req_i[owner_q]
                     || (slice_end && |(bus.req_i & ~gnt_q))
                     || preempt;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    led_d   = led_q;
    unique case (state_q)
      IDLE: begin
        led_d = '0;
        if (pick_valid) begin
          gnt_d   = win_gnt;
          owner_d = win_idx;
          hold_d  = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        led_d  = bus.pat_i[int'(owner_q)*LED_NUM +: LED_NUM];
        hold_d = hold_q + HOLD_CW'(1);
        if (release_now) begin
          gnt_d   = '0;
          led_d   = '0;
          state_d = GAP;
        end else if (slice_end) begin
          hold_d = '0;
        end
      end
      GAP: begin
        ptr_d   = (owner_q == PW'(REQ_NUM - 1)) ? '0 : owner_q + PW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
    end
  end

  assign bus.gnt_o  = gnt_q;
  assign bus.busy_o = |gnt_q;
  assign bus.done_o = (state_q == GAP);

  always_comb begin
    for (int unsigned i = 0; i < LED_NUM; i++) begin
      bus.led_o[i] = led_pin(led_q[i], LED_ON_MODE);
    end
  end

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Directed bench for led_bank_arbiter with a 5-cycle hold slice, active-low LEDs.
module tb_led_bank_arbiter;

  localparam int REQ_NUM = 4;
  localparam int LED_NUM = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  led_bank_arbiter_if #(.REQ_NUM(REQ_NUM), .LED_NUM(LED_NUM)) bus ();

  led_bank_arbiter #(
    .REQ_NUM     (REQ_NUM),
    .LED_NUM     (LED_NUM),
    .LED_ON_MODE (1'b0),
    .CLK_FREQ    (1000),
    .HOLD_MS     (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0;
    bus.pat_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_i = '0;
    bus.pat_i = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.led_o !== 8'hFF || bus.gnt_o !== 4'b0000 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_vals led=%h gnt=%b busy=%b done=%b exp led=ff gnt=0000 busy=0 done=0",
               bus.led_o, bus.gnt_o, bus.busy_o, bus.done_o);
    end
    rst = 1'b0;
    @(negedge clk);
    bus.req_i = 4'b0100;
    bus.pat_i = 32'h000F_0000;
    @(negedge clk);
    tests_run++;
    if (bus.gnt_o !== 4'b0100 || bus.busy_o !== 1'b1 || bus.led_o !== 8'hFF) begin
      tests_failed++;
      $display("FAIL first_grant gnt=%b busy=%b led=%h exp gnt=0100 busy=1 led=ff",
               bus.gnt_o, bus.busy_o, bus.led_o);
    end
    @(negedge clk);
    tests_run++;
    if (bus.led_o !== 8'hF0) begin
      tests_failed++;
      $display("FAIL first_led got=%h exp=f0", bus.led_o);
    end
  endtask

  // requesters 1 and 2 alternate: 5 held cycles, 1 GAP, 1 IDLE per owner
  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    logic [7:0] exp_led;
    logic       exp_done;
    int         p;
    int         slot;
    do_reset();
    bus.pat_i = 32'h0004_0200;
    bus.req_i = 4'b0110;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      p    = (k - 1) % 7;
      slot = ((k - 1) / 7) % 2;
      exp_gnt  = (p < 5) ? ((slot == 1) ? 4'b0100 : 4'b0010) : 4'b0000;
      exp_done = (p == 5);
      exp_led  = (p >= 1 && p <= 4) ? ((slot == 1) ? 8'hFB : 8'hFD) : 8'hFF;
      tests_run++;
      if (bus.gnt_o !== exp_gnt || bus.done_o !== exp_done || bus.led_o !== exp_led) begin
        tests_failed++;
        $display("FAIL rr_cycle k=%0d gnt=%b done=%b led=%h exp gnt=%b done=%b led=%h",
                 k, bus.gnt_o, bus.done_o, bus.led_o, exp_gnt, exp_done, exp_led);
      end
    end
  endtask

  task automatic test_single_hold();
    logic [7:0] exp_led;
    do_reset();
    bus.pat_i = 32'h0000_A500;
    bus.req_i = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_led = (k == 1) ? 8'hFF : 8'h5A;
      tests_run++;
      if (bus.gnt_o !== 4'b0010 || bus.done_o !== 1'b0 || bus.led_o !== exp_led) begin
        tests_failed++;
        $display("FAIL single_hold k=%0d gnt=%b done=%b led=%h exp gnt=0010 done=0 led=%h",
                 k, bus.gnt_o, bus.done_o, bus.led_o, exp_led);
      end
    end
  endtask

  task automatic test_early_release();
    logic [3:0] exp_gnt [1:5];
    logic       exp_done[1:5];
    exp_gnt  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    bus.pat_i = 32'h3C11_0000;
    bus.req_i = 4'b1100;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.gnt_o !== exp_gnt[k] || bus.done_o !== exp_done[k]) begin
        tests_failed++;
        $display("FAIL early_release k=%0d gnt=%b done=%b exp gnt=%b done=%b",
                 k, bus.gnt_o, bus.done_o, exp_gnt[k], exp_done[k]);
      end
      if (k == 2) bus.req_i = 4'b1000;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.pat_i = 32'h3C00_0000;
    bus.req_i = 4'b1000;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.gnt_o !== 4'b1000 || bus.led_o !== 8'hC3) begin
      tests_failed++;
      $display("FAIL pre_reset_own gnt=%b led=%h exp gnt=1000 led=c3", bus.gnt_o, bus.led_o);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if (bus.gnt_o !== 4'b0000 || bus.led_o !== 8'hFF || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset gnt=%b led=%h busy=%b done=%b exp gnt=0000 led=ff busy=0 done=0",
               bus.gnt_o, bus.led_o, bus.busy_o, bus.done_o);
    end
    bus.req_i = 4'b1001;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.gnt_o !== 4'b0001) begin
      tests_failed++;
      $display("FAIL post_reset_ptr gnt=%b exp=0001", bus.gnt_o);
    end
  endtask

  task automatic test_preempt();
    logic [3:0] exp_gnt [1:8];
    logic       exp_done[1:8];
`ifdef LED_ARB_PREEMPT_EN
    exp_gnt  = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_done = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_gnt  = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0001};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`endif
    do_reset();
    bus.pat_i = 32'h0081_0000;
    bus.req_i = 4'b0100;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.gnt_o !== exp_gnt[k] || bus.done_o !== exp_done[k]) begin
        tests_failed++;
        $display("FAIL preempt k=%0d gnt=%b done=%b exp gnt=%b done=%b",
                 k, bus.gnt_o, bus.done_o, exp_gnt[k], exp_done[k]);
      end
      if (k == 2) bus.req_i = 4'b0101;
    end
  endtask

  initial begin
    bus.req_i = '0;
    bus.pat_i = '0;
    test_reset();
    test_round_robin();
    test_single_hold();
    test_early_release();
    test_async_reset();
    test_preempt();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
